// File: rtl/iccm_fetch_align_if.sv
// Fetch-unit bundle: ICCM read port toward the memory, instruction stream toward the decoder.
interface iccm_fetch_align_if #(
  parameter int AddrWidth = 15
);
  logic [AddrWidth-1:0] iccm_addr;
  logic                 iccm_read;
  logic [15:0]          iccm_lsb;
  logic [15:0]          iccm_msb;
  logic [31:0]          instr;
  logic [31:0]          pc;
  logic                 compressed;
  logic                 valid;
  logic                 ready;
  logic                 misaligned;

  modport master (
    output iccm_addr, iccm_read, instr, pc, compressed, valid, misaligned,
    input  iccm_lsb, iccm_msb, ready
  );

  modport slave (
    input  iccm_addr, iccm_read, instr, pc, compressed, valid, misaligned,
    output iccm_lsb, iccm_msb, ready
  );
endinterface

// File: rtl/iccm_fetch_align.sv
// ICCM instruction fetch with RVC alignment: reads one halfword pair per cycle,
// sizes the instruction from its low bits and queues it in a 2-entry FIFO.
module iccm_fetch_align #(
  parameter int          AddrWidth = 15,
  parameter logic [31:0] BootAddr  = 32'h0000_0000
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst_n,
  input  logic                 i_start,
  input  logic                 i_redirect,
  input  logic [31:0]          i_redirect_pc,
  output logic [AddrWidth-1:0] iccm_addr,
  output logic                 iccm_read,
  input  logic [15:0]          iccm_lsb,
  input  logic [15:0]          iccm_msb,
  output logic [31:0]          o_instr,
  output logic [31:0]          o_pc,
  output logic                 o_compressed,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_misaligned
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, ERROR = 2'd2} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        compressed;
  } entry_t;

  state_e       state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [1:0]   count_q, count_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         mis_q, mis_d;
  entry_t [1:0] fifo_q;
  entry_t       new_entry;
  logic         rvc, flush, push, pop;

  assign rvc       = (iccm_lsb[1:0] != 2'b11);
  assign new_entry = '{instr:      rvc ? {16'h0000, iccm_lsb} : {iccm_msb, iccm_lsb},
                       pc:         fetch_pc_q,
                       compressed: rvc};

  // Truncation of the halfword index makes the ICCM wrap naturally.
  assign iccm_addr    = fetch_pc_q[AddrWidth:1];
  assign o_valid      = (count_q != 2'd0);
  assign o_instr      = fifo_q[rd_ptr_q].instr;
  assign o_pc         = fifo_q[rd_ptr_q].pc;
  assign o_compressed = fifo_q[rd_ptr_q].compressed;
  assign o_misaligned = mis_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mis_d      = mis_q;
    flush      = 1'b0;
    iccm_read  = 1'b0;

    case (state_q)
      FETCH:   iccm_read = (count_q < 2'd2);
      default: iccm_read = 1'b0;
    endcase

    // Redirect beats start beats normal queue traffic; both flush the FIFO.
    if (i_redirect) begin
      flush = 1'b1;
      if (i_redirect_pc[0]) begin
        state_d = ERROR;
        mis_d   = 1'b1;
      end else begin
        state_d    = FETCH;
        fetch_pc_d = i_redirect_pc;
        mis_d      = 1'b0;
      end
    end else if (i_start) begin
      flush      = 1'b1;
      state_d    = FETCH;
      fetch_pc_d = BootAddr;
      mis_d      = 1'b0;
    end else if (iccm_read) begin
      fetch_pc_d = fetch_pc_q + (rvc ? 32'd2 : 32'd4);
    end

    push     = iccm_read && !flush;
    pop      = o_valid && i_ready && !flush;
    count_d  = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d = flush ? 1'b0 : rd_ptr_q ^ pop;
    wr_ptr_d = flush ? 1'b0 : wr_ptr_q ^ push;
  end

  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= BootAddr;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      mis_q      <= 1'b0;
      fifo_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      mis_q      <= mis_d;
      if (push) fifo_q[wr_ptr_q] <= new_entry;
    end
  end
endmodule

// File: tb/tb_iccm_fetch_align.sv
// Directed + randomized bench: the expected stream is derived by walking the ICCM
// image from the architectural PC, independent of any FIFO bookkeeping.
module tb_iccm_fetch_align;
  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam int M_IDLE = 0, M_FETCH = 1, M_ERROR = 2;

  logic        brq_clk, brq_rst_n, i_start, i_redirect;
  logic [31:0] i_redirect_pc;
  logic [15:0] iccm_mem [0:32767];

  int          n_checks = 0, n_err = 0;
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_mis;
  logic        h_hold;
  logic [31:0] h_pc, h_instr;

  iccm_fetch_align_if #(.AddrWidth(15)) bus ();

  assign bus.iccm_lsb = iccm_mem[bus.iccm_addr];
  assign bus.iccm_msb = iccm_mem[bus.iccm_addr + 15'd1];

  iccm_fetch_align #(.AddrWidth(15), .BootAddr(BOOT)) dut (
    .brq_clk      (brq_clk),
    .brq_rst_n    (brq_rst_n),
    .i_start      (i_start),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .iccm_addr    (bus.iccm_addr),
    .iccm_read    (bus.iccm_read),
    .iccm_lsb     (bus.iccm_lsb),
    .iccm_msb     (bus.iccm_msb),
    .o_instr      (bus.instr),
    .o_pc         (bus.pc),
    .o_compressed (bus.compressed),
    .o_valid      (bus.valid),
    .i_ready      (bus.ready),
    .o_misaligned (bus.misaligned)
  );

  initial brq_clk = 1'b0;
  always #5 brq_clk = ~brq_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural instruction at a byte PC, straight from the ICCM image.
  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    logic [14:0] a;
    logic [15:0] lo, hi;
    a  = pc[15:1];
    lo = iccm_mem[a];
    hi = iccm_mem[a + 15'd1];
    return (lo[1:0] != 2'b11) ? {16'h0000, lo} : {hi, lo};
  endfunction

  function automatic logic [31:0] ref_len(input logic [31:0] pc);
    logic [31:0] w;
    w = ref_instr(pc);
    return (w[1:0] == 2'b11) ? 32'd4 : 32'd2;
  endfunction

  task automatic model_check();
    logic [31:0] ei;
    check("misaligned", 32'(bus.misaligned), 32'(m_mis));
    if (m_mode != M_FETCH) begin
      check("inactive_valid", 32'(bus.valid), 32'd0);
      check("inactive_read", 32'(bus.iccm_read), 32'd0);
    end
    if (h_hold) begin
      check("hold_valid", 32'(bus.valid), 32'd1);
      check("hold_pc", bus.pc, h_pc);
      check("hold_instr", bus.instr, h_instr);
    end
    if (bus.valid) begin
      ei = ref_instr(m_pc);
      check("head_pc", bus.pc, m_pc);
      check("head_instr", bus.instr, ei);
      check("head_rvc", 32'(bus.compressed), 32'(ei[1:0] != 2'b11));
    end
    h_hold  = bus.valid && !bus.ready;
    h_pc    = bus.pc;
    h_instr = bus.instr;
    if (bus.valid && bus.ready) m_pc = m_pc + ref_len(m_pc);
    if (i_redirect) begin
      h_hold = 1'b0;
      if (i_redirect_pc[0]) begin
        m_mode = M_ERROR;
        m_mis  = 1'b1;
      end else begin
        m_mode = M_FETCH;
        m_pc   = i_redirect_pc;
        m_mis  = 1'b0;
      end
    end else if (i_start) begin
      h_hold = 1'b0;
      m_mode = M_FETCH;
      m_pc   = BOOT;
      m_mis  = 1'b0;
    end
  endtask

  task automatic cyc();
    #1;
    model_check();
    @(posedge brq_clk);
    @(negedge brq_clk);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_mis  = 1'b0;
    m_pc   = BOOT;
    h_hold = 1'b0;
  endtask

  task automatic do_reset();
    brq_rst_n = 1'b0;
    model_reset();
    @(posedge brq_clk);
    @(negedge brq_clk);
    brq_rst_n = 1'b1;
  endtask

  initial begin
    int r;
    for (int i = 0; i < 32768; i++) iccm_mem[i] = 16'($urandom);
    brq_rst_n = 1'b0; i_start = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    bus.ready = 1'b0;
    model_reset();

    // Reset state
    @(negedge brq_clk);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_read", 32'(bus.iccm_read), 32'd0);
    check("rst_mis", 32'(bus.misaligned), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_pc", bus.pc, 32'd0);
    check("rst_rvc", 32'(bus.compressed), 32'd0);
    check("rst_addr", 32'(bus.iccm_addr), 32'(BOOT[15:1]));
    brq_rst_n = 1'b1;
    cyc();
    cyc();

    // Mixed 32/16-bit boot sequence, then sustained throughput
    iccm_mem[0] = 16'h0513; iccm_mem[1] = 16'h0000; iccm_mem[2] = 16'h4501;
    bus.ready = 1'b1;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    check("start_addr", 32'(bus.iccm_addr), 32'd0);
    check("start_read", 32'(bus.iccm_read), 32'd1);
    cyc();
    check("boot0_valid", 32'(bus.valid), 32'd1);
    check("boot0_instr", bus.instr, 32'h0000_0513);
    check("boot0_pc", bus.pc, 32'd0);
    check("boot0_rvc", 32'(bus.compressed), 32'd0);
    cyc();
    check("boot1_instr", bus.instr, 32'h0000_4501);
    check("boot1_pc", bus.pc, 32'd4);
    check("boot1_rvc", 32'(bus.compressed), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("thru_valid", 32'(bus.valid), 32'd1);
    end

    // Backpressure: FIFO saturates, head held, drained in order
    do_reset();
    iccm_mem[0] = 16'h0513; iccm_mem[1] = 16'h1234;
    iccm_mem[2] = 16'h0593; iccm_mem[3] = 16'h5678;
    iccm_mem[4] = 16'h0613; iccm_mem[5] = 16'h9abc;
    bus.ready = 1'b0;
    i_start = 1'b1; cyc(); i_start = 1'b0;
    cyc(); cyc();
    check("full_read", 32'(bus.iccm_read), 32'd0);
    check("full_valid", 32'(bus.valid), 32'd1);
    check("full_pc", bus.pc, 32'd0);
    cyc();
    check("full_read2", 32'(bus.iccm_read), 32'd0);
    check("full_pc2", bus.pc, 32'd0);
    bus.ready = 1'b1;
    check("drain0_instr", bus.instr, 32'h1234_0513);
    cyc();
    check("drain1_pc", bus.pc, 32'd4);
    check("drain1_instr", bus.instr, 32'h5678_0593);
    cyc();
    check("drain2_pc", bus.pc, 32'd8);
    check("drain2_instr", bus.instr, 32'h9abc_0613);

    // Redirect while full
    bus.ready = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    check("refill_read", 32'(bus.iccm_read), 32'd0);
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0010; cyc(); i_redirect = 1'b0;
    check("redir_valid", 32'(bus.valid), 32'd0);
    check("redir_addr", 32'(bus.iccm_addr), 32'd8);
    cyc();
    check("redir_head_valid", 32'(bus.valid), 32'd1);
    check("redir_head_pc", bus.pc, 32'h0000_0010);

    // Misaligned redirect, recovery through start
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0011; cyc(); i_redirect = 1'b0;
    check("mis_flag", 32'(bus.misaligned), 32'd1);
    check("mis_valid", 32'(bus.valid), 32'd0);
    check("mis_read", 32'(bus.iccm_read), 32'd0);
    bus.ready = 1'b1;
    cyc(); cyc();
    i_start = 1'b1; cyc(); i_start = 1'b0;
    check("recov_mis", 32'(bus.misaligned), 32'd0);
    check("recov_addr", 32'(bus.iccm_addr), 32'(BOOT[15:1]));
    cyc();
    check("recov_valid", 32'(bus.valid), 32'd1);
    check("recov_pc", bus.pc, BOOT);

    // 32-bit instruction straddling the ICCM wrap
    do_reset();
    iccm_mem[32767] = 16'h0093; iccm_mem[0] = 16'h0000;
    bus.ready = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_FFFE; cyc(); i_redirect = 1'b0;
    check("wrap_addr", 32'(bus.iccm_addr), 32'h7FFF);
    cyc();
    check("wrap_instr", bus.instr, 32'h0000_0093);
    check("wrap_pc", bus.pc, 32'h0000_FFFE);
    check("wrap_rvc", 32'(bus.compressed), 32'd0);
    check("wrap_next_addr", 32'(bus.iccm_addr), 32'd1);
    cyc(); cyc();

    // Randomized traffic against the reference walk
    for (int i = 0; i < 1500; i++) begin
      bus.ready = ($urandom_range(9) < 7);
      r = $urandom_range(99);
      if (r < 3) begin
        i_redirect = 1'b1; i_redirect_pc = $urandom & 32'hFFFF_FFFE;
      end else if (r < 4) begin
        i_redirect = 1'b1; i_redirect_pc = $urandom | 32'h1;
      end else if (m_mode != M_FETCH && r < 20) begin
        i_start = 1'b1;
      end
      cyc();
      i_redirect = 1'b0; i_start = 1'b0;
    end

    // Asynchronous reset mid-stream
    bus.ready = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0100; cyc(); i_redirect = 1'b0;
    cyc(); cyc();
    check("pre_rst_valid", 32'(bus.valid), 32'd1);
    #2;
    brq_rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_valid", 32'(bus.valid), 32'd0);
    check("async_rst_read", 32'(bus.iccm_read), 32'd0);
    @(negedge brq_clk);
    brq_rst_n = 1'b1;
    cyc(); cyc(); cyc();
    check("post_rst_valid", 32'(bus.valid), 32'd0);
    check("post_rst_read", 32'(bus.iccm_read), 32'd0);
    i_start = 1'b1; cyc(); i_start = 1'b0;
    cyc();
    check("restart_valid", 32'(bus.valid), 32'd1);
    check("restart_pc", bus.pc, BOOT);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/iccm_fetch_align.md
ICCM_FETCH_ALIGN -- requirements
Module: iccm_fetch_align

Interface
REQ-001 SHALL have parameter AddrWidth, default 15, ICCM halfword-index width.
REQ-002 SHALL have parameter BootAddr, default 32'h0000_0000, byte PC loaded on start.
REQ-003 SHALL have port brq_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port brq_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  pulse; begin fetching from BootAddr.
REQ-006 SHALL have port i_redirect  input  1  pulse; flush and refetch from i_redirect_pc.
REQ-007 SHALL have port i_redirect_pc  input  32  byte redirect target.
REQ-008 SHALL have port iccm_addr  output  AddrWidth  halfword index = fetch_pc[AddrWidth:1].
REQ-009 SHALL have port iccm_read  output  1  ICCM read enable.
REQ-010 SHALL have port iccm_lsb  input  16  halfword at iccm_addr, valid same cycle.
REQ-011 SHALL have port iccm_msb  input  16  halfword at iccm_addr+1, valid same cycle.
REQ-012 SHALL have port o_instr  output  32  instruction at queue head.
REQ-013 SHALL have port o_pc  output  32  byte PC of o_instr.
REQ-014 SHALL have port o_compressed  output  1  head is 16-bit RVC.
REQ-015 SHALL have port o_valid  output  1  head valid.
REQ-016 SHALL have port i_ready  input  1  consumer accepts head.
REQ-017 SHALL have port o_misaligned  output  1  odd redirect target error flag.

Function
REQ-018 SHALL implement states IDLE, FETCH, ERROR; reset state IDLE.
REQ-019 IDLE: iccm_read=0; IDLE->FETCH on i_start, fetch_pc<=BootAddr.
REQ-020 FETCH: iccm_read=1 iff queue count<2 (registered count); no read when full.
REQ-021 SHALL classify per cycle of iccm_read: iccm_lsb[1:0]!=2'b11 -> compressed, entry {16'h0,iccm_lsb}, fetch_pc+=2; else entry {iccm_msb,iccm_lsb}, fetch_pc+=4.
REQ-022 SHALL push {instr, fetch_pc, compressed} into a 2-entry FIFO at the rising edge of each iccm_read cycle.
REQ-023 fetch_pc arithmetic SHALL be 32-bit modulo; iccm_addr truncation wraps the last halfword to index 0, and a 32-bit instruction at the last halfword takes msb from index 0 (ICCM wrap).
REQ-024 o_valid=1 iff count>0; o_instr/o_pc/o_compressed SHALL hold stable while o_valid && !i_ready.
REQ-025 Pop on o_valid && i_ready; simultaneous push and pop with count=1 leaves count=1, new entry behind head.
REQ-026 i_redirect with i_redirect_pc[0]=0, any state: flush FIFO (count=0 next cycle), fetch_pc<=i_redirect_pc, state->FETCH, o_misaligned<=0.
REQ-027 i_redirect with i_redirect_pc[0]=1: flush FIFO, state->ERROR, o_misaligned<=1.
REQ-028 ERROR: iccm_read=0, o_valid=0, o_misaligned held 1; ERROR->FETCH on i_start (fetch_pc<=BootAddr) or aligned redirect.
REQ-029 Priority SHALL be i_redirect > i_start > push/pop in same cycle; a pop coinciding with redirect counts as consumed, pushed data that cycle discarded.
REQ-030 Latency: aligned redirect/start at edge N -> iccm_addr shows new PC in cycle N+1 -> o_valid=1 with that instruction in cycle N+2.
REQ-031 Throughput: one instruction per cycle sustained when i_ready=1 continuously.

Reset
REQ-032 brq_rst_n=0 SHALL asynchronously force state=IDLE, count=0, fetch_pc=BootAddr, o_valid=0, iccm_read=0, o_misaligned=0, o_instr=0, o_pc=0, o_compressed=0.
REQ-033 Reset asserted mid-FETCH SHALL discard FIFO contents; fetch resumes only after i_start post-deassertion.

Verification
REQ-034 ICCM[0..2]=16'h0513,16'h0000,16'h4501; i_start, i_ready=1 -> o_instr 32'h0000_0513 pc 0 compressed 0, then 32'h0000_4501 pc 4 compressed 1.
REQ-035 i_ready=0 after start with 32-bit instructions at 0,4,8 -> count saturates 2, iccm_read=0, o_pc=0 held stable; i_ready=1 -> pcs 0,4,8 in order, no loss/duplication.
REQ-036 Redirect to 32'h0000_0010 while FIFO full -> o_valid=0 next cycle, iccm_addr=8 next cycle, o_pc=32'h10 two cycles after redirect.
REQ-037 Redirect to 32'h0000_0011 -> o_misaligned=1, o_valid=0, iccm_read=0; subsequent i_start -> o_misaligned=0, o_pc=BootAddr.
REQ-038 32-bit instruction at halfword 32767 (lsb 16'h0093, halfword 0=16'h0000) -> o_instr 32'h0000_0093, o_pc 32'h0000_FFFE, next fetch index 1.
REQ-039 brq_rst_n=0 mid-stream with o_valid=1 -> o_valid=0 and iccm_read=0 immediately, no output until i_start.
